arith_arbiter: RTL and testbench

ARITH_ARBITER -- requirements
Module: arith_arbiter

---
 rtl/arith_arbiter.sv | 145 ++++++++++++++
 tb/tb_arith_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/arith_arbiter.sv
// rtl/arith_arbiter.sv - two-requester round-robin arbiter feeding a one-cycle 16-bit ALU
// Optional rsp_flag output enabled by defining ARITH_ARBITER_FLAGS_EN.
module arith_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
`ifdef ARITH_ARBITER_FLAGS_EN
  output logic        rsp_flag,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  state_t      state;
  logic        ptr;
  logic [1:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        id_q;
  logic        grant0;
  logic        grant1;
  logic [15:0] alu_res;

  // Grants are combinational in IDLE; the pointer only breaks ties.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !ptr);
      grant1 = req1_valid && (!req0_valid || ptr);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_res = 16'h0000;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_MUL:  alu_res = a_q * b_q;
      OP_AND:  alu_res = a_q & b_q;
      default: alu_res = 16'h0000;
    endcase
  end

`ifdef ARITH_ARBITER_FLAGS_EN
  logic [16:0] sum_wide;
  logic [31:0] prod_wide;
  logic        alu_flag;

  always_comb begin
    sum_wide  = {1'b0, a_q} + {1'b0, b_q};
    prod_wide = {16'h0000, a_q} * {16'h0000, b_q};
    alu_flag  = 1'b0;
    case (op_q)
      OP_ADD:  alu_flag = sum_wide[16];
      OP_SUB:  alu_flag = (a_q < b_q);
      OP_MUL:  alu_flag = (prod_wide[31:16] != 16'h0000);
      OP_AND:  alu_flag = ((a_q & b_q) == 16'h0000);
      default: alu_flag = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      rsp_flag <= 1'b0;
    else if (state == EXEC)
      rsp_flag <= alu_flag;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op_q      <= 2'b00;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      id_q      <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_q  <= grant1 ? req1_op : req0_op;
            a_q   <= grant1 ? req1_a  : req0_a;
            b_q   <= grant1 ? req1_b  : req0_b;
            id_q  <= grant1;
            ptr   <= grant0;
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          rsp_data  <= alu_res;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Result stays parked here until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_arbiter.sv
// tb/tb_arith_arbiter.sv - directed self-checking bench for arith_arbiter
module tb_arith_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        busy;
`ifdef ARITH_ARBITER_FLAGS_EN
  logic        rsp_flag;
`endif

  int checks = 0;
  int errors = 0;

  arith_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
`ifdef ARITH_ARBITER_FLAGS_EN
    .rsp_flag   (rsp_flag),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    req0_op    = 2'b00;
    req0_a     = 16'h0000;
    req0_b     = 16'h0000;
    req1_valid = 1'b0;
    req1_op    = 2'b00;
    req1_a     = 16'h0000;
    req1_b     = 16'h0000;
    tick();
    tick();

    // Reset state, and no grant while reset is high
    req0_valid = 1'b1;
    #1;
    check("reset_req0_ready", req0_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_data", rsp_data, 16'h0000);
    check("reset_rsp_id", rsp_id, 0);

    // Single add 3+4
    reset   = 1'b0;
    req0_op = 2'b00;
    req0_a  = 16'h0003;
    req0_b  = 16'h0004;
    #1;
    check("add_c0_req0_ready", req0_ready, 1);
    check("add_c0_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("add_c1_busy", busy, 1);
    check("add_c1_rsp_valid", rsp_valid, 0);
    tick();
    check("add_c2_rsp_valid", rsp_valid, 1);
    check("add_c2_rsp_id", rsp_id, 0);
    check("add_c2_rsp_data", rsp_data, 16'h0007);
    tick();
    check("add_c3_busy", busy, 0);
    check("add_c3_rsp_valid", rsp_valid, 0);

    // Re-reset so the pointer starts at req0, then contend continuously
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    req0_valid = 1'b1;
    req0_op    = 2'b01;
    req0_a     = 16'h0005;
    req0_b     = 16'h0007;
    req1_valid = 1'b1;
    req1_op    = 2'b10;
    req1_a     = 16'h0100;
    req1_b     = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_req0_ready", i), req0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_req1_ready", i), req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("rr%0d_exec_ready", i), {req0_ready, req1_ready}, 2'b00);
      tick();
      check($sformatf("rr%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("rr%0d_rsp_id", i), rsp_id, i % 2);
      check($sformatf("rr%0d_rsp_data", i), rsp_data, (i % 2 == 0) ? 16'hFFFE : 16'h0000);
`ifdef ARITH_ARBITER_FLAGS_EN
      check($sformatf("rr%0d_rsp_flag", i), rsp_flag, 1);
`endif
      tick();
    end

    // Stall in RESP for 10 cycles while req1 waits
    req1_valid = 1'b0;
    req0_op    = 2'b00;
    req0_a     = 16'h1234;
    req0_b     = 16'h1111;
    rsp_ready  = 1'b0;
    #1;
    check("stall_accept_req0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_op    = 2'b11;
    req1_a     = 16'hFFFF;
    req1_b     = 16'h00FF;
    #1;
    check("stall_exec_req1_ready", req1_ready, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("stall%0d_rsp_data", i), rsp_data, 16'h2345);
      check($sformatf("stall%0d_req1_ready", i), req1_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_release_rsp_valid", rsp_valid, 1);
    check("stall_release_req1_ready", req1_ready, 0);
    tick();
    check("stall_req1_granted", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("stall_req1_rsp_id", rsp_id, 1);
    check("stall_req1_rsp_data", rsp_data, 16'h00FF);
    tick();

    // Reset during EXEC aborts the operation
    req0_valid = 1'b1;
    req0_op    = 2'b00;
    req0_a     = 16'h0001;
    req0_b     = 16'h0001;
    #1;
    check("abort_accept", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_quiet%0d", i), rsp_valid, 0);
    end

    // Pointer back at 0: and F0F0 & 0F0F with both valid
    req0_valid = 1'b1;
    req0_op    = 2'b11;
    req0_a     = 16'hF0F0;
    req0_b     = 16'h0F0F;
    req1_valid = 1'b1;
    req1_op    = 2'b00;
    #1;
    check("ptr_reset_req0_ready", req0_ready, 1);
    check("ptr_reset_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("and_rsp_valid", rsp_valid, 1);
    check("and_rsp_data", rsp_data, 16'h0000);
`ifdef ARITH_ARBITER_FLAGS_EN
    check("and_rsp_flag", rsp_flag, 1);
`endif
    tick();

    // Carry wrap FFFF + 0001
    req0_valid = 1'b1;
    req0_op    = 2'b00;
    req0_a     = 16'hFFFF;
    req0_b     = 16'h0001;
    #1;
    check("carry_accept", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("carry_rsp_valid", rsp_valid, 1);
    check("carry_rsp_data", rsp_data, 16'h0000);
`ifdef ARITH_ARBITER_FLAGS_EN
    check("carry_rsp_flag", rsp_flag, 1);
`endif
    tick();
    check("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
